// File: rtl/sc_pkg.sv
// Shared types, constants and arithmetic helpers for the scan-converter output post-processing path.
package sc_pkg;

  typedef enum logic [1:0] {
    SL_OFF = 2'd0,
    SL_H   = 2'd1,
    SL_V   = 2'd2,
    SL_HV  = 2'd3
  } sl_mode_e;

  typedef struct packed {
    logic [10:0] h_start;
    logic [10:0] h_end;
    logic [10:0] v_start;
    logic [10:0] v_end;
  } win_t;

  localparam bit SYNC_POL_DEFAULT = 1'b0;
  localparam int PP_LATENCY       = 4;

  // MSB replication, cycling through the source bits until out_bits are produced.
  function automatic logic [15:0] expand_depth(input logic [15:0] x, input int in_bits,
                                               input int out_bits);
    logic [15:0] r;
    r = '0;
    for (int i = 0; i < out_bits; i++) begin
      r = (r << 1) | ((x >> (in_bits - 1 - (i % in_bits))) & 16'd1);
    end
    return r;
  endfunction

  function automatic logic [15:0] sl_strength(input logic [3:0] str, input int out_bits);
    return ((16'(str) + 16'd1) << (out_bits - 4)) - 16'd1;
  endfunction

  function automatic logic [15:0] sat_sub(input logic [15:0] a, input logic [15:0] b);
    return (a > b) ? (a - b) : 16'd0;
  endfunction

endpackage

// File: rtl/sc_cfg_shadow.sv
// Double-buffered configuration: writes land in a shadow set that is copied to the
// active set only when a swap request arrives while an update is pending.
module sc_cfg_shadow #(
  parameter int W = 8
) (
  input  logic         PCLK_out,
  input  logic         reset_n,
  input  logic         cfg_update,
  input  logic [W-1:0] cfg_in,
  input  logic         swap,
  output logic [W-1:0] cfg_act,
  output logic         cfg_pending
);

  logic [W-1:0] shadow_reg;

  // A write coinciding with a swap applies the old shadow and leaves the new one pending.
  always_ff @(posedge PCLK_out or negedge reset_n) begin
    if (!reset_n) begin
      shadow_reg  <= '0;
      cfg_act     <= '0;
      cfg_pending <= 1'b0;
    end else begin
      if (cfg_update) shadow_reg <= cfg_in;
      if (swap && cfg_pending) cfg_act <= shadow_reg;
      if (cfg_update) cfg_pending <= 1'b1;
      else if (swap) cfg_pending <= 1'b0;
    end
  end

endmodule

// File: rtl/sc_postproc.sv
// Four-stage output post-processing: depth expansion, H/V scanlines and border masking,
// with per-frame double-buffered configuration swapped on the VSYNC leading edge.
module sc_postproc
  import sc_pkg::*;
#(
  parameter int IN_BITS  = 5,
  parameter int OUT_BITS = 8,
  parameter int ID_BITS  = 3,
  parameter int NUM_IDS  = 5,
  parameter bit SYNC_POL = SYNC_POL_DEFAULT
) (
  input  logic                PCLK_out,
  input  logic                reset_n,
  input  logic [IN_BITS-1:0]  R_in,
  input  logic [IN_BITS-1:0]  G_in,
  input  logic [IN_BITS-1:0]  B_in,
  input  logic                HSYNC_in,
  input  logic                VSYNC_in,
  input  logic                DE_in,
  input  logic [10:0]         hcnt,
  input  logic [10:0]         vcnt,
  input  logic [ID_BITS-1:0]  line_id,
  input  logic [ID_BITS-1:0]  col_id,
  input  logic [1:0]          cfg_sl_mode,
  input  logic [3:0]          cfg_sl_str,
  input  logic [NUM_IDS-1:0]  cfg_sl_lines,
  input  logic [3:0]          cfg_mask_br,
  input  logic [10:0]         cfg_h_start,
  input  logic [10:0]         cfg_h_end,
  input  logic [10:0]         cfg_v_start,
  input  logic [10:0]         cfg_v_end,
  input  logic                cfg_update,
  output logic                cfg_pending,
  output logic [OUT_BITS-1:0] R_out,
  output logic [OUT_BITS-1:0] G_out,
  output logic [OUT_BITS-1:0] B_out,
  output logic                HSYNC_out,
  output logic                VSYNC_out,
  output logic                DE_out
);

  localparam int CFG_W = 2 + 4 + NUM_IDS + 4 + $bits(win_t);
  localparam int NLP   = 2 ** ID_BITS;
  localparam int NCH   = 3;

  logic [CFG_W-1:0]   cfg_in, cfg_act;
  logic [1:0]         act_mode;
  logic [3:0]         act_str;
  logic [NUM_IDS-1:0] act_lines;
  logic [3:0]         act_br;
  win_t               act_win;
  logic [NLP-1:0]     lines_pad;
  logic               vs_edge, mask_c, hit_c;
  logic [OUT_BITS-1:0] str_c;

  logic               s1_hs, s1_vs, s1_de, s1_mask, s1_hit;
  logic [OUT_BITS-1:0] s1_str;
  logic [3:0]         s1_br;
  logic               s2_hs, s2_vs, s2_de, s2_mask, s2_hit;
  logic [OUT_BITS-1:0] s2_str;
  logic [3:0]         s2_br;
  logic               s3_hs, s3_vs, s3_de, s3_mask;
  logic [3:0]         s3_br;
  logic [OUT_BITS-1:0] br_ext;

  logic [IN_BITS-1:0]  pix_in  [NCH];
  logic [IN_BITS-1:0]  s1_pix  [NCH];
  logic [OUT_BITS-1:0] s2_pix  [NCH];
  logic [OUT_BITS-1:0] s3_pix  [NCH];
  logic [OUT_BITS-1:0] out_pix [NCH];

  assign cfg_in = {cfg_sl_mode, cfg_sl_str, cfg_sl_lines, cfg_mask_br,
                   cfg_h_start, cfg_h_end, cfg_v_start, cfg_v_end};
  assign {act_mode, act_str, act_lines, act_br, act_win} = cfg_act;

  // Leading edge: input at the active level while the stage-1 copy is still inactive.
  assign vs_edge = (VSYNC_in == SYNC_POL) && (s1_vs != SYNC_POL);

  sc_cfg_shadow #(.W(CFG_W)) u_cfg_shadow (
    .PCLK_out    (PCLK_out),
    .reset_n     (reset_n),
    .cfg_update  (cfg_update),
    .cfg_in      (cfg_in),
    .swap        (vs_edge),
    .cfg_act     (cfg_act),
    .cfg_pending (cfg_pending)
  );

  // line_id values beyond the mask width never select a scanline.
  for (genvar gi = 0; gi < NLP; gi++) begin : g_lines
    if (gi < NUM_IDS) begin : g_on
      assign lines_pad[gi] = act_lines[gi];
    end else begin : g_off
      assign lines_pad[gi] = 1'b0;
    end
  end

  assign mask_c = DE_in & ((hcnt < act_win.h_start) | (hcnt >= act_win.h_end) |
                           (vcnt < act_win.v_start) | (vcnt >= act_win.v_end));
  assign hit_c  = (((act_mode == SL_H) || (act_mode == SL_HV)) && lines_pad[line_id]) ||
                  (((act_mode == SL_V) || (act_mode == SL_HV)) && (col_id == '0));
  assign str_c  = OUT_BITS'(sl_strength(act_str, OUT_BITS));
  assign br_ext = OUT_BITS'(s3_br) << (OUT_BITS - 4);

  // Config-derived controls travel with each pixel so a swap never splits a pixel's treatment.
  always_ff @(posedge PCLK_out or negedge reset_n) begin
    if (!reset_n) begin
      s1_hs <= ~SYNC_POL; s1_vs <= ~SYNC_POL; s1_de <= 1'b0; s1_mask <= 1'b0; s1_hit <= 1'b0;
      s1_str <= '0; s1_br <= '0;
      s2_hs <= ~SYNC_POL; s2_vs <= ~SYNC_POL; s2_de <= 1'b0; s2_mask <= 1'b0; s2_hit <= 1'b0;
      s2_str <= '0; s2_br <= '0;
      s3_hs <= ~SYNC_POL; s3_vs <= ~SYNC_POL; s3_de <= 1'b0; s3_mask <= 1'b0; s3_br <= '0;
      HSYNC_out <= ~SYNC_POL; VSYNC_out <= ~SYNC_POL; DE_out <= 1'b0;
    end else begin
      s1_hs <= HSYNC_in; s1_vs <= VSYNC_in; s1_de <= DE_in; s1_mask <= mask_c; s1_hit <= hit_c;
      s1_str <= str_c; s1_br <= act_br;
      s2_hs <= s1_hs; s2_vs <= s1_vs; s2_de <= s1_de; s2_mask <= s1_mask; s2_hit <= s1_hit;
      s2_str <= s1_str; s2_br <= s1_br;
      s3_hs <= s2_hs; s3_vs <= s2_vs; s3_de <= s2_de; s3_mask <= s2_mask; s3_br <= s2_br;
      HSYNC_out <= s3_hs; VSYNC_out <= s3_vs; DE_out <= s3_de;
    end
  end

  assign pix_in[0] = R_in;
  assign pix_in[1] = G_in;
  assign pix_in[2] = B_in;

  for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
    always_ff @(posedge PCLK_out or negedge reset_n) begin
      if (!reset_n) begin
        s1_pix[gi]  <= '0;
        s2_pix[gi]  <= '0;
        s3_pix[gi]  <= '0;
        out_pix[gi] <= '0;
      end else begin
        s1_pix[gi]  <= pix_in[gi];
        s2_pix[gi]  <= OUT_BITS'(expand_depth(16'(s1_pix[gi]), IN_BITS, OUT_BITS));
        s3_pix[gi]  <= s2_hit ? OUT_BITS'(sat_sub(16'(s2_pix[gi]), 16'(s2_str))) : s2_pix[gi];
        out_pix[gi] <= !s3_de ? '0 : (s3_mask ? br_ext : s3_pix[gi]);
      end
    end
  end

  assign R_out = out_pix[0];
  assign G_out = out_pix[1];
  assign B_out = out_pix[2];

endmodule

// File: tb/tb_sc_postproc.sv
// Scoreboard bench for sc_postproc: directed pixels push expected outputs, a monitor
// compares them PP_LATENCY cycles later.
module tb_sc_postproc;
  import sc_pkg::*;

  logic       PCLK_out = 1'b0;
  logic       reset_n  = 1'b0;
  logic [4:0] R_in, G_in, B_in;
  logic       HSYNC_in, VSYNC_in, DE_in;
  logic [10:0] hcnt, vcnt;
  logic [2:0] line_id, col_id;
  logic [1:0] cfg_sl_mode;
  logic [3:0] cfg_sl_str;
  logic [4:0] cfg_sl_lines;
  logic [3:0] cfg_mask_br;
  logic [10:0] cfg_h_start, cfg_h_end, cfg_v_start, cfg_v_end;
  logic       cfg_update;
  logic       cfg_pending;
  logic [7:0] R_out, G_out, B_out;
  logic       HSYNC_out, VSYNC_out, DE_out;

  sc_postproc dut (
    .PCLK_out(PCLK_out), .reset_n(reset_n),
    .R_in(R_in), .G_in(G_in), .B_in(B_in),
    .HSYNC_in(HSYNC_in), .VSYNC_in(VSYNC_in), .DE_in(DE_in),
    .hcnt(hcnt), .vcnt(vcnt), .line_id(line_id), .col_id(col_id),
    .cfg_sl_mode(cfg_sl_mode), .cfg_sl_str(cfg_sl_str), .cfg_sl_lines(cfg_sl_lines),
    .cfg_mask_br(cfg_mask_br), .cfg_h_start(cfg_h_start), .cfg_h_end(cfg_h_end),
    .cfg_v_start(cfg_v_start), .cfg_v_end(cfg_v_end), .cfg_update(cfg_update),
    .cfg_pending(cfg_pending),
    .R_out(R_out), .G_out(G_out), .B_out(B_out),
    .HSYNC_out(HSYNC_out), .VSYNC_out(VSYNC_out), .DE_out(DE_out)
  );

  always #5 PCLK_out = ~PCLK_out;

  int cyc = 0;
  always @(posedge PCLK_out) cyc <= cyc + 1;

  typedef struct {
    int         due;
    int         tag;
    logic [7:0] r, g, b;
    logic       hs, vs, de;
  } exp_t;

  exp_t q[$];
  int errors = 0;
  int checks = 0;
  int tag_cnt = 0;

  always @(negedge PCLK_out) begin
    exp_t e;
    while (q.size() > 0 && q[0].due <= cyc) begin
      e = q.pop_front();
      checks++;
      if (e.due != cyc ||
          {R_out, G_out, B_out, HSYNC_out, VSYNC_out, DE_out} !== {e.r, e.g, e.b, e.hs, e.vs, e.de}) begin
        errors++;
        $display("FAIL pix%0d: got rgb=%h_%h_%h hs=%b vs=%b de=%b, want rgb=%h_%h_%h hs=%b vs=%b de=%b",
                 e.tag, R_out, G_out, B_out, HSYNC_out, VSYNC_out, DE_out,
                 e.r, e.g, e.b, e.hs, e.vs, e.de);
      end else begin
        $display("pix%0d ok: rgb=%h_%h_%h hs=%b vs=%b de=%b", e.tag, R_out, G_out, B_out,
                 HSYNC_out, VSYNC_out, DE_out);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end else begin
      $display("%s ok: %0h", name, act);
    end
  endtask

  // Drive one pixel for one cycle and queue its expected output.
  task automatic px(input logic [4:0] r, g, b, input logic de, hs, vs,
                    input logic [10:0] h, v, input logic [2:0] lid, cid,
                    input logic [7:0] er, eg, eb);
    exp_t e;
    R_in = r; G_in = g; B_in = b; DE_in = de; HSYNC_in = hs; VSYNC_in = vs;
    hcnt = h; vcnt = v; line_id = lid; col_id = cid;
    e.due = cyc + PP_LATENCY; e.tag = tag_cnt; e.r = er; e.g = eg; e.b = eb;
    e.hs = hs; e.vs = vs; e.de = de;
    tag_cnt++;
    q.push_back(e);
    @(negedge PCLK_out);
  endtask

  task automatic set_cfg(input logic [1:0] m, input logic [3:0] s, input logic [4:0] l,
                         input logic [3:0] br, input logic [10:0] hs0, he, vs0, ve);
    cfg_sl_mode = m; cfg_sl_str = s; cfg_sl_lines = l; cfg_mask_br = br;
    cfg_h_start = hs0; cfg_h_end = he; cfg_v_start = vs0; cfg_v_end = ve;
  endtask

  task automatic write_cfg(input logic [1:0] m, input logic [3:0] s, input logic [4:0] l,
                           input logic [3:0] br, input logic [10:0] hs0, he, vs0, ve);
    set_cfg(m, s, l, br, hs0, he, vs0, ve);
    cfg_update = 1'b1;
    @(negedge PCLK_out);
    cfg_update = 1'b0;
  endtask

  task automatic vedge();
    VSYNC_in = 1'b0;
    @(negedge PCLK_out);
    VSYNC_in = 1'b1;
    @(negedge PCLK_out);
  endtask

  initial begin
    R_in = '0; G_in = '0; B_in = '0; HSYNC_in = 1'b1; VSYNC_in = 1'b1; DE_in = 1'b0;
    hcnt = '0; vcnt = '0; line_id = '0; col_id = '0; cfg_update = 1'b0;
    set_cfg(2'd0, 4'd0, 5'd0, 4'd0, 11'd0, 11'd0, 11'd0, 11'd0);
    repeat (3) @(negedge PCLK_out);
    reset_n = 1'b1;
    @(negedge PCLK_out);
    chk("rst_rgb", 32'({R_out, G_out, B_out}), 32'h0);
    chk("rst_hs", 32'(HSYNC_out), 32'h1);
    chk("rst_vs", 32'(VSYNC_out), 32'h1);
    chk("rst_de", 32'(DE_out), 32'h0);
    chk("rst_pend", 32'(cfg_pending), 32'h0);

    // Full window, scanlines off: plain depth expansion.
    write_cfg(2'd0, 4'd0, 5'd0, 4'd0, 11'd0, 11'd2047, 11'd0, 11'd2047);
    chk("pend_set", 32'(cfg_pending), 32'h1);
    vedge();
    chk("pend_clr", 32'(cfg_pending), 32'h0);
    px(5'h00, 5'h00, 5'h00, 1'b0, 1'b1, 1'b1, 11'd99, 11'd100, 3'd7, 3'd1, 8'h00, 8'h00, 8'h00);
    px(5'h1F, 5'h10, 5'h04, 1'b1, 1'b0, 1'b1, 11'd100, 11'd100, 3'd7, 3'd1, 8'hFF, 8'h84, 8'h21);
    px(5'h00, 5'h01, 5'h1F, 1'b1, 1'b1, 1'b1, 11'd101, 11'd100, 3'd7, 3'd1, 8'h00, 8'h08, 8'hFF);

    // H+V scanlines, strength 3 -> subtract 0x3F.
    write_cfg(2'd3, 4'd3, 5'b00010, 4'd0, 11'd0, 11'd2047, 11'd0, 11'd2047);
    vedge();
    px(5'h1F, 5'h10, 5'h04, 1'b1, 1'b1, 1'b1, 11'd100, 11'd100, 3'd1, 3'd2, 8'hC0, 8'h45, 8'h00);
    px(5'h1F, 5'h10, 5'h04, 1'b1, 1'b1, 1'b1, 11'd100, 11'd100, 3'd0, 3'd0, 8'hC0, 8'h45, 8'h00);
    px(5'h1F, 5'h10, 5'h04, 1'b1, 1'b1, 1'b1, 11'd100, 11'd100, 3'd1, 3'd0, 8'hC0, 8'h45, 8'h00);
    px(5'h1F, 5'h10, 5'h04, 1'b1, 1'b1, 1'b1, 11'd100, 11'd100, 3'd2, 3'd3, 8'hFF, 8'h84, 8'h21);

    // Border window h 64..1343, brightness 0xA.
    write_cfg(2'd0, 4'd0, 5'd0, 4'hA, 11'd64, 11'd1343, 11'd0, 11'd2047);
    vedge();
    px(5'h1F, 5'h10, 5'h04, 1'b1, 1'b1, 1'b1, 11'd63, 11'd100, 3'd1, 3'd0, 8'hA0, 8'hA0, 8'hA0);
    px(5'h1F, 5'h10, 5'h04, 1'b1, 1'b1, 1'b1, 11'd64, 11'd100, 3'd1, 3'd0, 8'hFF, 8'h84, 8'h21);
    px(5'h1F, 5'h10, 5'h04, 1'b1, 1'b1, 1'b1, 11'd1342, 11'd100, 3'd1, 3'd0, 8'hFF, 8'h84, 8'h21);
    px(5'h1F, 5'h10, 5'h04, 1'b1, 1'b1, 1'b1, 11'd1343, 11'd100, 3'd1, 3'd0, 8'hA0, 8'hA0, 8'hA0);
    px(5'h1F, 5'h10, 5'h04, 1'b0, 1'b1, 1'b1, 11'd63, 11'd100, 3'd1, 3'd0, 8'h00, 8'h00, 8'h00);

    // Mid-frame update to H scanlines: held until the next VSYNC leading edge.
    write_cfg(2'd1, 4'd3, 5'b00010, 4'hA, 11'd0, 11'd2047, 11'd0, 11'd2047);
    chk("mid_pend", 32'(cfg_pending), 32'h1);
    px(5'h1F, 5'h10, 5'h04, 1'b1, 1'b1, 1'b1, 11'd100, 11'd100, 3'd1, 3'd5, 8'hFF, 8'h84, 8'h21);
    px(5'h1F, 5'h10, 5'h04, 1'b1, 1'b1, 1'b0, 11'd100, 11'd100, 3'd1, 3'd5, 8'hFF, 8'h84, 8'h21);
    px(5'h1F, 5'h10, 5'h04, 1'b1, 1'b1, 1'b0, 11'd100, 11'd100, 3'd1, 3'd5, 8'hC0, 8'h45, 8'h00);
    chk("mid_pend_clr", 32'(cfg_pending), 32'h0);
    px(5'h1F, 5'h10, 5'h04, 1'b1, 1'b1, 1'b1, 11'd10, 11'd100, 3'd1, 3'd5, 8'hC0, 8'h45, 8'h00);

    // Update coincident with the edge: V mode applied, degenerate window stays pending.
    write_cfg(2'd2, 4'd3, 5'b00010, 4'hA, 11'd0, 11'd2047, 11'd0, 11'd2047);
    set_cfg(2'd0, 4'd0, 5'd0, 4'h5, 11'd500, 11'd500, 11'd0, 11'd2047);
    cfg_update = 1'b1; VSYNC_in = 1'b0;
    @(negedge PCLK_out);
    cfg_update = 1'b0; VSYNC_in = 1'b1;
    chk("coin_pend", 32'(cfg_pending), 32'h1);
    px(5'h1F, 5'h10, 5'h04, 1'b1, 1'b1, 1'b1, 11'd10, 11'd100, 3'd7, 3'd0, 8'hC0, 8'h45, 8'h00);
    vedge();
    chk("coin_pend_clr", 32'(cfg_pending), 32'h0);
    px(5'h1F, 5'h10, 5'h04, 1'b1, 1'b1, 1'b1, 11'd10, 11'd100, 3'd7, 3'd0, 8'h50, 8'h50, 8'h50);
    px(5'h1F, 5'h10, 5'h04, 1'b1, 1'b1, 1'b1, 11'd2000, 11'd100, 3'd7, 3'd0, 8'h50, 8'h50, 8'h50);
    repeat (PP_LATENCY + 1) @(negedge PCLK_out);

    // Asynchronous reset mid-line, checked before the next clock edge.
    #2 reset_n = 1'b0;
    #1;
    chk("arst_rgb", 32'({R_out, G_out, B_out}), 32'h0);
    chk("arst_sync", 32'({HSYNC_out, VSYNC_out}), 32'h3);
    chk("arst_de", 32'(DE_out), 32'h0);
    @(negedge PCLK_out);
    reset_n = 1'b1;
    chk("arst_pend", 32'(cfg_pending), 32'h0);
    // Reset config masks every pixel with brightness 0.
    px(5'h1F, 5'h10, 5'h04, 1'b1, 1'b1, 1'b1, 11'd100, 11'd100, 3'd1, 3'd0, 8'h00, 8'h00, 8'h00);
    repeat (PP_LATENCY + 2) @(negedge PCLK_out);

    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL sb_drain: got %0d entries left want 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sc_postproc.md
Name: sc_postproc

Overview:
- Parametrised output-side post-processing pipeline for the scan converter. Runs in the PCLK_out domain.
- Takes line-buffer pixel data plus externally generated timing and counters.
- Operations: expands colour depth by MSB replication; applies H, V or combined H+V scanlines; generates a border mask from a programmable active window.
- Config is double-buffered and swapped only at a frame boundary, so CPU writes never tear a frame.

Parameters:
- IN_BITS, 5, colour bits per channel at input.
- OUT_BITS, 8, colour bits per channel at output; must satisfy OUT_BITS >= IN_BITS and OUT_BITS >= 4.
- ID_BITS, 3, width of line_id/col_id.
- NUM_IDS, 5, width of the scanline line-select mask; NUM_IDS <= 2**ID_BITS.
- SYNC_POL, 0, active level of HSYNC/VSYNC.

Ports:
- PCLK_out  in  1  output pixel clock
- reset_n  in  1  asynchronous, active-low reset
- R_in, G_in, B_in  in  IN_BITS each  line-buffer pixel data, aligned with the timing inputs
- HSYNC_in, VSYNC_in, DE_in  in  1  output timing
- hcnt, vcnt  in  11  output pixel/line counters
- line_id, col_id  in  ID_BITS  sub-line/sub-column index within the multiplied pixel
- cfg_sl_mode  in  2  0=off, 1=H, 2=V, 3=H+V
- cfg_sl_str  in  4  scanline strength
- cfg_sl_lines  in  NUM_IDS  line_id select mask for H scanlines
- cfg_mask_br  in  4  border brightness
- cfg_h_start, cfg_h_end, cfg_v_start, cfg_v_end  in  11  unmasked window
- cfg_update  in  1  one-cycle pulse that captures all cfg_* inputs into the shadow set
- cfg_pending  out  1  shadow captured but not yet applied
- R_out, G_out, B_out  out  OUT_BITS
- HSYNC_out, VSYNC_out, DE_out  out  1

Behaviour:
- Reset (async assert, sync release):
  - RGB outputs = 0; HSYNC_out/VSYNC_out = ~SYNC_POL; DE_out = 0.
  - cfg_pending = 0; active config = all zero (mode off, window 0..0, so everything masked, brightness 0).
  - Pipeline registers cleared.
- Latency: exactly 4 PCLK_out cycles from any input to the corresponding output, for every signal. No bubbles, no stalls.
- Stage 1: register inputs. Compute mask_en = DE_in & (hcnt<h_start | hcnt>=h_end | vcnt<v_start | vcnt>=v_end). Detect the VSYNC leading edge from VSYNC_in vs its stage-1 copy.
- Stage 2: depth expansion, channel value = {x, x[IN_BITS-1 -: OUT_BITS-IN_BITS]}, with replication repeated if OUT_BITS > 2*IN_BITS. Examples: 5'h1F -> 8'hFF; 5'h10 -> 8'h84.
- Stage 3: scanlines, with str_ext = ((str+1) << (OUT_BITS-4)) - 1.
  - H hit = mode[0] & cfg_sl_lines[line_id], where line_id >= NUM_IDS means no hit.
  - V hit = mode[1] & (col_id == 0).
  - Any hit gives the saturating result max(data - str_ext, 0). H and V hits do not stack; the subtraction is applied once.
- Stage 4:
  - DE low: RGB forced to 0.
  - Else if mask_en: RGB = {br, zeros}.
  - Else: scanline result.
- Config swap:
  - cfg_update sets cfg_pending and loads the shadow set.
  - On an input VSYNC leading edge with cfg_pending=1, the shadow is copied to active and cfg_pending clears the next cycle.
  - The new config affects pixels entering stage 1 on the cycle after the edge.
  - cfg_update on the same cycle as the edge: the old shadow is applied, the new values are captured, and cfg_pending stays 1.
  - cfg_update during a frame repeatedly: last write wins.
- Window degenerate cases:
  - h_start >= h_end: all pixels in the line are masked.
  - h_end > hcnt max: the right border is never masked.
- Reset mid-frame: outputs return immediately to the reset values, and the active config returns to the reset config.

Decomposition:
- Shared package sc_pkg holds:
  - scanline mode constants SL_OFF/SL_H/SL_V/SL_HV;
  - the sync polarity default;
  - the pipeline latency constant PP_LATENCY=4;
  - functions expand_depth(), sl_strength(), sat_sub().
- One natural sub-module, sc_cfg_shadow: shadow/active register set plus the swap logic. It is reusable for other per-frame config blocks.

Test Plan:
- Reset release with all inputs idle -> R/G/B_out=0, HSYNC_out=VSYNC_out=1, DE_out=0, cfg_pending=0.
- Mode off, window 0..2047 both axes, R_in=5'h1F, DE_in=1 -> R_out=8'hFF exactly 4 cycles later, with HSYNC/VSYNC/DE delayed identically.
- cfg_sl_mode=3, str=4'h3 (str_ext=8'h3F), cfg_sl_lines=5'b00010, G_in=5'h10 (8'h84):
  - line_id=1, col_id=2 -> 8'h45;
  - line_id=0, col_id=0 -> 8'h45;
  - line_id=1, col_id=0 -> 8'h45 (no double subtract);
  - B_in=5'h04 (8'h21) on a hit -> 8'h00 (saturation).
- Window h 64..1343, br=4'hA, DE=1: hcnt=63 -> RGB=8'hA0; hcnt=64 -> pixel data; hcnt=1343 -> 8'hA0. DE=0 at any hcnt -> RGB=0.
- cfg_update mid-frame changing mode 0->1 -> cfg_pending=1, output unchanged until the VSYNC leading edge, then scanlines from the next frame and cfg_pending=0.
- cfg_update coincident with the VSYNC edge -> previous shadow applied, new value pending until the following edge.
- Async reset asserted mid-line -> outputs at reset values within the same cycle, with no X; after release, behaviour matches the post-reset config.
